tt_um_ziyi_yuchen: RTL and testbench

Single-channel 8-bit PWM controller packaged as a TinyTapeout user tile. Two push-button inputs step the duty cycle up or down. A free-running 8-bit counter, with an optional prescaler, generates the PWM waveform on the dedicated outputs. The current duty value is exported on the bidirectional pins for observation.

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/edge_sync.sv | 28 ++
 rtl/tt_um_ziyi_yuchen.sv | 97 +++++++++
 tb/tb_tt_um_ziyi_yuchen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and types for the tile PWM controller.
// Duty defaults and the prescale-select encoding live here.
package pwm_pkg;

    localparam int DUTY_W     = 8;
    localparam int DUTY_STEP  = 16;
    localparam int DUTY_RESET = 128;

    typedef enum logic [1:0] {
        PSC_DIV1 = 2'b00,
        PSC_DIV2 = 2'b01,
        PSC_DIV4 = 2'b10,
        PSC_DIV8 = 2'b11
    } psc_sel_e;

    // Tick fires when all masked prescale bits are set.
    function automatic logic [2:0] psc_mask(input psc_sel_e sel);
        logic [2:0] m;
        m = 3'b000;
        case (sel)
            PSC_DIV1: m = 3'b000;
            PSC_DIV2: m = 3'b001;
            PSC_DIV4: m = 3'b011;
            PSC_DIV8: m = 3'b111;
            default:  m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector.
// Emits a single-cycle pulse per low-to-high input transition.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            hist_q <= s2_q;
        end
    end

    assign rise = s2_q & ~hist_q;

endmodule

// File: rtl/tt_um_ziyi_yuchen.sv
// Button-stepped 8-bit PWM tile with prescaled free-running counter.
// Duty changes are latched into the compare only at period start.
module tt_um_ziyi_yuchen
    import pwm_pkg::*;
#(
    parameter int DUTY_STEP  = pwm_pkg::DUTY_STEP,
    parameter int DUTY_RESET = pwm_pkg::DUTY_RESET
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [DUTY_W-1:0] RST_DUTY = DUTY_W'(DUTY_RESET);
    localparam logic [DUTY_W:0]   STEP9    = (DUTY_W+1)'(DUTY_STEP);

    logic              up_ev;
    logic              dn_ev;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] duty_d;
    logic [DUTY_W-1:0] act_q;
    logic [DUTY_W-1:0] cnt_q;
    logic [2:0]        psc_q;
    logic [2:0]        mask;
    logic              tick;
    logic              pwm_q;
    logic              npwm_q;
    logic              pulse_q;
    logic [DUTY_W:0]   sum;
    logic [DUTY_W:0]   diff;
    logic              unused;

    edge_sync u_up (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[0]),
        .rise  (up_ev)
    );

    edge_sync u_dn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[1]),
        .rise  (dn_ev)
    );

    assign sum  = {1'b0, duty_q} + STEP9;
    assign diff = {1'b0, duty_q} - STEP9;

    // Bit 8 flags overflow on add and borrow on subtract.
    always_comb begin
        duty_d = duty_q;
        case ({up_ev, dn_ev})
            2'b10:   duty_d = sum[DUTY_W] ? '1 : sum[DUTY_W-1:0];
            2'b01:   duty_d = diff[DUTY_W] ? '0 : diff[DUTY_W-1:0];
            default: duty_d = duty_q;
        endcase
    end

    assign mask = psc_mask(psc_sel_e'(ui_in[7:6]));
    assign tick = (psc_q & mask) == mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q  <= RST_DUTY;
            act_q   <= RST_DUTY;
            cnt_q   <= '0;
            psc_q   <= '0;
            pwm_q   <= 1'b0;
            npwm_q  <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            duty_q  <= duty_d;
            psc_q   <= psc_q + 3'd1;
            pwm_q   <= cnt_q < act_q;
            npwm_q  <= !(cnt_q < act_q);
            pulse_q <= tick && (cnt_q == '0);
            if (tick) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == '1)
                    act_q <= duty_q;
            end
        end
    end

    assign uo_out  = {5'b0, pulse_q, npwm_q, pwm_q};
    assign uio_out = duty_q;
    assign uio_oe  = 8'hFF;

    assign unused = &{1'b0, ena, uio_in, ui_in[5:2]};

endmodule

// File: tb/tb_tt_um_ziyi_yuchen.sv
// Scoreboard bench for the button-stepped PWM tile.
// Expected duty and period figures are queued, then popped on output.
module tb_tt_um_ziyi_yuchen;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;
    int duty_m;
    int exp_q[$];

    tt_um_ziyi_yuchen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pop_exp();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    function automatic int step(input int d, input bit up, input bit dn);
        if (up && !dn) return (d + 16 > 255) ? 255 : d + 16;
        if (dn && !up) return (d - 16 < 0) ? 0 : d - 16;
        return d;
    endfunction

    task automatic press(input bit up, input bit dn);
        int old;
        old    = duty_m;
        duty_m = step(duty_m, up, dn);
        exp_q.push_back(duty_m);
        @(negedge clk);
        ui_in[1:0] = {dn, up};
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("duty_lat", int'(uio_out), old);
        @(posedge clk);
        @(negedge clk);
        check("duty", int'(uio_out), pop_exp());
        repeat (8) @(negedge clk);
        check("duty_held", int'(uio_out), duty_m);
        ui_in[1:0] = 2'b00;
        repeat (5) @(negedge clk);
        check("duty_rel", int'(uio_out), duty_m);
    endtask

    task automatic wait_pulse();
        int n;
        n = 0;
        while (!uo_out[2] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!uo_out[2]) check("pulse_timeout", 0, 1);
    endtask

    // Counts one full period between period-start pulses.
    task automatic measure(input int press_at);
        int per;
        int hi;
        int lo;
        wait_pulse();
        per = 0;
        hi  = 0;
        lo  = 0;
        do begin
            hi += int'(uo_out[0]);
            lo += int'(uo_out[1]);
            if (per == press_at) ui_in[0] = 1'b1;
            if (per == press_at + 10) ui_in[0] = 1'b0;
            per++;
            @(negedge clk);
        end while (!uo_out[2] && per < 5000);
        check("period", per, pop_exp());
        check("high", hi, pop_exp());
        check("low_n", lo, pop_exp());
    endtask

    task automatic expect_period(input int per, input int hi);
        exp_q.push_back(per);
        exp_q.push_back(hi);
        exp_q.push_back(per - hi);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        duty_m = 128;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_duty", int'(uio_out), 128);
        check("rst_uo", int'(uo_out), 2);
        check("rst_oe", int'(uio_oe), 255);
        rst_n = 1'b1;

        expect_period(256, 128);
        measure(-1);

        press(1'b1, 1'b0);
        expect_period(256, 144);
        measure(-1);
        press(1'b0, 1'b1);
        expect_period(256, 128);
        measure(-1);

        press(1'b1, 1'b1);

        // Mid-period press keeps the current period at the old duty.
        expect_period(256, 128);
        measure(50);
        duty_m = 144;
        repeat (4) @(negedge clk);
        check("glitch_duty", int'(uio_out), duty_m);
        expect_period(256, 144);
        measure(-1);

        for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
        check("sat_hi", int'(uio_out), 255);
        expect_period(256, 255);
        measure(-1);
        measure_extra_hi();

        for (int i = 0; i < 17; i++) press(1'b0, 1'b1);
        check("sat_lo", int'(uio_out), 0);
        expect_period(256, 0);
        measure(-1);

        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        ui_in[7:6] = 2'b11;
        wait_pulse();
        @(negedge clk);
        expect_period(2048, 512);
        measure(-1);
        ui_in[7:6] = 2'b00;

        // Asynchronous reset mid-period.
        repeat (37) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("arst_duty", int'(uio_out), 128);
        check("arst_uo", int'(uo_out), 2);
        @(negedge clk);
        rst_n  = 1'b1;
        duty_m = 128;
        expect_period(256, 128);
        measure(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic measure_extra_hi();
        press(1'b1, 1'b0);
        check("sat_hold", int'(uio_out), 255);
    endtask

endmodule
